// File: rtl/serial_ling_adder_if.sv
// Operand/result handshake bundle for serial_ling_adder.
// Producer/consumer side uses master; the adder uses slave.
interface serial_ling_adder_if #(
    parameter int unsigned NBYTES = 8
);
    localparam int unsigned W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_ling_adder.sv
// Byte-serial adder: one 8-bit slice per cycle, LSB first.
// The inter-byte carry uses the group generate/propagate of each byte pair.
module serial_ling_adder #(
    parameter int unsigned NBYTES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_ling_adder_if.slave   bus
);
    localparam int unsigned         W        = 8 * NBYTES;
    localparam int unsigned         IDXW     = $clog2(NBYTES);
    localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            carry_q;
    logic [IDXW-1:0] idx_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [7:0]      a_byte_d;
    logic [7:0]      b_byte_d;
    logic [8:0]      pair_d;
    logic            gen_d;
    logic            prop_d;
    logic [7:0]      sum_byte_d;
    logic            carry_d;

    // Byte slice: generate/propagate come from a_i+b_i alone, so the carry
    // chain never waits on the incoming carry passing through the adder.
    always_comb begin
        a_byte_d   = a_q[8*idx_q +: 8];
        b_byte_d   = b_q[8*idx_q +: 8];
        pair_d     = {1'b0, a_byte_d} + {1'b0, b_byte_d};
        gen_d      = pair_d[8];
        prop_d     = (pair_d[7:0] == 8'hFF);
        sum_byte_d = pair_d[7:0] + {7'd0, carry_q};
        carry_d    = gen_d | (prop_d & carry_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        idx_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[8*idx_q +: 8] <= sum_byte_d;
                    carry_q             <= carry_d;
                    // Index resets on the last byte instead of wrapping past NBYTES-1.
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= carry_d;
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_ling_adder.sv
// Self-checking bench for serial_ling_adder: vector table, hand-written
// corner sequences and a queue scoreboard fed at every input handshake.
module tb_serial_ling_adder;
    localparam int unsigned NB = 8;
    localparam int unsigned W  = 8 * NB;
    localparam int unsigned RW = W + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_ling_adder_if #(.NBYTES(NB)) bus ();
    serial_ling_adder #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_vec = 0;
    int           n_err = 0;
    int           n_out = 0;
    int           cyc   = 0;
    int           last_out = -1;
    bit           b2b = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic [W:0]   sb[$];
    logic [W:0]   exp_r;
    vec_t         vecs[8];

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_sum", RW'(bus.sum), RW'(prev_sum));
                check("hold_cout", RW'(bus.cout), RW'(prev_cout));
            end
            check("ready_and_valid", RW'(bus.in_ready & bus.out_valid), RW'(0));
            if (bus.in_valid && bus.in_ready)
                sb.push_back({1'b0, bus.a} + {1'b0, bus.b} + RW'(bus.cin));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("dup_result", RW'(1), RW'(0));
                end else begin
                    exp_r = sb.pop_front();
                    check("sb_sum", RW'(bus.sum), RW'(exp_r[W-1:0]));
                    check("sb_cout", RW'(bus.cout), RW'(exp_r[W]));
                end
                if (b2b && last_out >= 0)
                    check("b2b_period", RW'(cyc - last_out), RW'(NB + 2));
                last_out = cyc;
                n_out++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
            prev_cout  = bus.cout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!bus.in_ready) check("in_ready_timeout", RW'(bus.in_ready), RW'(1));
    endtask

    // Operands are scrambled right after capture so late input changes would show up.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        wait_ready();
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept(input logic [W-1:0] s, input logic c);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("post_in_ready", RW'(bus.in_ready), RW'(1));
        check("post_out_valid", RW'(bus.out_valid), RW'(0));
        check("post_busy", RW'(bus.busy), RW'(0));
        check("retain_sum", RW'(bus.sum), RW'(s));
        check("retain_cout", RW'(bus.cout), RW'(c));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int lat;
        int target;
        int k;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;

        vecs[0] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0, cin: 1'b1, sum: 64'h0, cout: 1'b1};
        vecs[1] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'hFEDC_BA98_7654_3210, cin: 1'b0,
                    sum: 64'hFFFF_FFFF_FFFF_FFFF, cout: 1'b0};
        vecs[2] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'hFEDC_BA98_7654_3210, cin: 1'b1,
                    sum: 64'h0, cout: 1'b1};
        vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0,
                    sum: 64'h0, cout: 1'b1};
        vecs[4] = '{a: 64'h0, b: 64'h0, cin: 1'b0, sum: 64'h0, cout: 1'b0};
        vecs[5] = '{a: 64'h0000_0000_0000_00FF, b: 64'h1, cin: 1'b0,
                    sum: 64'h0000_0000_0000_0100, cout: 1'b0};
        vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1,
                    sum: 64'hFFFF_FFFF_FFFF_FFFF, cout: 1'b1};
        vecs[7] = '{a: 64'h00FF_00FF_00FF_00FF, b: 64'h00FF_00FF_00FF_00FF, cin: 1'b0,
                    sum: 64'h01FE_01FE_01FE_01FE, cout: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", RW'(bus.in_ready), RW'(1));
        check("rst_out_valid", RW'(bus.out_valid), RW'(0));
        check("rst_busy", RW'(bus.busy), RW'(0));
        check("rst_sum", RW'(bus.sum), RW'(0));
        check("rst_cout", RW'(bus.cout), RW'(0));

        // Table vectors; out_valid first seen NB edges after capture, i.e. in cycle NB+1.
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            check("run_busy", RW'(bus.busy), RW'(1));
            check("run_in_ready", RW'(bus.in_ready), RW'(0));
            wait_done(lat);
            check("latency", RW'(lat), RW'(NB));
            check("vec_sum", RW'(bus.sum), RW'(vecs[i].sum));
            check("vec_cout", RW'(bus.cout), RW'(vecs[i].cout));
            check("done_busy", RW'(bus.busy), RW'(1));
            accept(vecs[i].sum, vecs[i].cout);
        end

        // Consumer stall with in_valid pulsed on new operands.
        start_op(64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b0);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1)) | (i == 0);
            bus.a        = {$urandom, $urandom};
            bus.b        = {$urandom, $urandom};
            tick();
            check("stall_in_ready", RW'(bus.in_ready), RW'(0));
            check("stall_out_valid", RW'(bus.out_valid), RW'(1));
            check("stall_sum", RW'(bus.sum), RW'(0));
            check("stall_cout", RW'(bus.cout), RW'(1));
        end
        bus.in_valid = 1'b0;
        accept(64'h0, 1'b1);
        check("stall_no_capture", RW'(sb.size()), RW'(0));
        check("stall_idle_busy", RW'(bus.busy), RW'(0));

        // Reset while processing byte 3, then a clean operation.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", RW'(bus.in_ready), RW'(1));
        check("abort_out_valid", RW'(bus.out_valid), RW'(0));
        check("abort_busy", RW'(bus.busy), RW'(0));
        check("abort_sum", RW'(bus.sum), RW'(0));
        check("abort_cout", RW'(bus.cout), RW'(0));
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_done(lat);
        check("post_rst_latency", RW'(lat), RW'(NB));
        check("post_rst_sum", RW'(bus.sum), RW'(0));
        check("post_rst_cout", RW'(bus.cout), RW'(1));
        accept(64'h0, 1'b1);

        // Back-to-back with both valids held high.
        b2b           = 1'b1;
        last_out      = -1;
        target        = n_out + 6;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        k = 0;
        while (n_out < target && k < 200) begin
            bus.a   = {$urandom, $urandom};
            bus.b   = {$urandom, $urandom};
            bus.cin = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        if (n_out < target) check("b2b_timeout", RW'(n_out), RW'(target));
        bus.in_valid = 1'b0;
        repeat (NB + 4) tick();
        b2b = 1'b0;
        check("b2b_drained", RW'(sb.size()), RW'(0));

        // Random operands with random producer/consumer stalls.
        target = n_out + 1500;
        k = 0;
        while (n_out < target && k < 60000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a         = {$urandom, $urandom};
            bus.b         = {$urandom, $urandom};
            bus.cin       = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        if (n_out < target) check("random_timeout", RW'(n_out), RW'(target));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NB + 4) tick();
        check("lost_result", RW'(sb.size()), RW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
